// File: rtl/bridge_uart_tx_if.sv
// Bridge slave bus bundle for the UART transmitter.
//   Addr[31:2] : word address from the Bridge (only Addr[3:2] decoded)
//   WE         : write strobe, asserted only inside this device's window
//   Din        : write data
//   Dout       : read data (combinational)
//   IRQ        : registered level interrupt request
// master = Bridge side, slave = peripheral side.
interface bridge_uart_tx_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/bridge_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the Bridge peripheral bus.
// The CPU pushes bytes into a TX FIFO; a baud-divider FSM serialises them.
// IRQ signals "transmitter drained" (IE & FIFO empty & FSM idle).
//
// Ports:
//   clk   : system clock, all state updates on posedge
//   reset : synchronous active-high reset
//   bus   : Bridge slave interface (Addr, WE, Din, Dout, IRQ)
//   tx    : serial line, idles high, driven from a register
//
// Register map (Addr[3:2]):
//   0 TXDATA  write pushes Din[7:0], reads 0
//   1 CTRL    {BUSY,FULL,EMPTY,PE,OVF,IE,EN} in bits [6:0]
//   2 DIV     clk cycles per bit, writes below 2 stored as 2
//   3 COUNT   FIFO occupancy
//
// Optional feature macro UART_PARITY_EN: adds CTRL bit3 PE and an even
// parity bit between the data bits and the stop bit when PE=1.
module bridge_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_RESET  = 16
) (
  input  logic             clk,
  input  logic             reset,
  bridge_uart_tx_if.slave  bus,
  output logic             tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic          en, ie, ie_d, ovf, pe;
  logic [15:0]   div_reg, div_act, baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg, shreg_d;
  logic          par_bit, pe_act;
  logic          tx_d, bit_end, pop, push;
  logic          empty, full, wr_data, wr_ctrl, wr_div;
  logic [1:0]    sel;
  logic          unused_ok;

  assign sel     = bus.Addr[3:2];
  assign wr_data = bus.WE && (sel == 2'd0);
  assign wr_ctrl = bus.WE && (sel == 2'd1);
  assign wr_div  = bus.WE && (sel == 2'd2);
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  // A push into a full FIFO still lands when the FSM pops in the same cycle.
  assign push    = wr_data && (!full || pop);
  assign ie_d    = wr_ctrl ? bus.Din[1] : ie;
  assign unused_ok = ^{bus.Addr[31:4], bus.Din[31:16]};

`ifndef UART_PARITY_EN
  assign pe = 1'b0;
`endif

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    shreg_d = shreg;
    bit_end = (baud_cnt == div_act - 16'd1);
    case (state)
      IDLE:   if (en && !empty) begin
                state_d = START;
                pop     = 1'b1;
              end
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end) begin
                shreg_d = shreg >> 1;
                if (bit_cnt == 3'd7) state_d = pe_act ? PARITY : STOP;
              end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) begin
                if (en && !empty) begin
                  state_d = START;
                  pop     = 1'b1;
                end else begin
                  state_d = IDLE;
                end
              end
      default: state_d = IDLE;
    endcase
    if (pop) shreg_d = mem[rd_ptr];
    // tx is the registered image of the next state's line level.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count + CNT_ONE;
      2'b01:   count_d = count - CNT_ONE;
      default: count_d = count;
    endcase
  end

  always_comb begin
    case (sel)
      2'd1:    bus.Dout = {25'd0, (state != IDLE), full, empty, pe, ovf, ie, en};
      2'd2:    bus.Dout = {16'd0, div_reg};
      2'd3:    bus.Dout = 32'(count);
      default: bus.Dout = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.Din[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      bus.IRQ  <= 1'b0;
      en       <= 1'b0;
      ie       <= 1'b0;
      ovf      <= 1'b0;
      div_reg  <= 16'(DIV_RESET);
      div_act  <= 16'(DIV_RESET);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      pe_act   <= 1'b0;
`ifdef UART_PARITY_EN
      pe       <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
      bus.IRQ <= ie_d && (count_d == '0) && (state_d == IDLE);
      count   <= count_d;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      if (pop) begin
        div_act  <= div_reg;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        par_bit  <= ^mem[rd_ptr];
        pe_act   <= pe;
      end else if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
        if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
      end

      if (wr_data && !push) ovf <= 1'b1;
      else if (wr_ctrl && bus.Din[2]) ovf <= 1'b0;

      if (wr_ctrl) begin
        en <= bus.Din[0];
        ie <= bus.Din[1];
`ifdef UART_PARITY_EN
        pe <= bus.Din[3];
`endif
      end

      if (wr_div) div_reg <= (bus.Din[15:0] < 16'd2) ? 16'd2 : bus.Din[15:0];
    end
  end

endmodule

// File: tb/tb_bridge_uart_tx.sv
// Self-checking bench for bridge_uart_tx: bytes pushed by the stimulus are
// queued with the divisor they should be sent at; an independent line
// receiver decodes every frame from tx and compares it against the queue.
module tb_bridge_uart_tx;

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   abort_mon = 1'b1;
  exp_t sb[$];
  int   start_times[$];
  int unsigned cur_div = 16;

  bridge_uart_tx_if bus ();

  bridge_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.Addr = {28'd0, a};
    bus.Din  = d;
    bus.WE   = 1'b1;
    @(posedge clk); #1;
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.Addr = {28'd0, a};
    bus.WE   = 1'b0;
    #1;
    v = bus.Dout;
  endtask

  task automatic set_div(input int unsigned d);
    wr(2'd2, d);
    cur_div = (d < 2) ? 2 : d;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_sent);
    exp_t e;
    e.data = b;
    e.div  = cur_div;
    if (expect_sent) sb.push_back(e);
    wr(2'd0, {24'd0, b});
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] v;
    int n = 0;
    do begin
      @(posedge clk); #1;
      rd(2'd1, v);
      n++;
    end while ((v[6] || !v[4]) && n < budget);
    tests++;
    if (v[6] || !v[4]) begin
      fails++;
      $display("FAIL drain_timeout: CTRL 0x%0h after %0d cycles, expected idle and empty", v, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Line receiver: every cycle of every bit must hold the expected level,
  // so both bit values and exact bit lengths are checked.
  initial begin : monitor
    logic prev = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (abort_mon) begin
        prev = 1'b1;
      end else if (prev && !tx) begin
        exp_t e;
        logic [9:0] rx = '0;
        logic glitch = 1'b0;
        bit aborted = 1'b0;
        start_times.push_back(cyc);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, expected none", cyc);
          e.data = 8'h00;
          e.div  = cur_div;
        end else begin
          e = sb.pop_front();
        end
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < int'(e.div); c++) begin
            if (!(b == 0 && c == 0)) begin
              @(posedge clk); #2;
              if (abort_mon) aborted = 1'b1;
            end
            if (aborted) break;
            if (c == 0) rx[b] = tx;
            else if (tx !== rx[b]) glitch = 1'b1;
          end
          if (aborted) break;
        end
        if (!aborted)
          check("frame", {21'd0, glitch, rx}, {21'd0, 1'b0, 1'b1, e.data, 1'b0});
        prev = aborted ? 1'b1 : tx;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL global_timeout: bench did not finish, fails so far %0d", fails);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] v;
    int hi;
    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.Din  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    abort_mon = 1'b0;

    // Reset state.
    rd(2'd1, v); check("rst_ctrl", v, 32'h10);
    rd(2'd2, v); check("rst_div", v, 32'd16);
    rd(2'd3, v); check("rst_count", v, 32'd0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, bus.IRQ}, 32'd0);

    // Single frame at DIV=4, with start latency and busy window.
    set_div(4);
    wr(2'd1, 32'h1);
    push_byte(8'h55, 1'b1);
    check("pre_start_tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    check("start_tx", {31'd0, tx}, 32'd0);
    repeat (39) @(posedge clk);
    #1;
    rd(2'd1, v); check("busy_end_frame", {31'd0, v[6]}, 32'd1);
    @(posedge clk); #1;
    rd(2'd1, v); check("idle_after_40", {31'd0, v[6]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back frames at DIV=2 with no idle gap.
    set_div(2);
    start_times.delete();
    push_byte(8'hA5, 1'b1);
    push_byte(8'h0F, 1'b1);
    wait_idle(200);
    check("b2b_frames", start_times.size(), 32'd2);
    if (start_times.size() == 2)
      check("b2b_period", start_times[1] - start_times[0], 32'd20);

    // Randomised rounds, including divisor clamping on readback.
    for (int r = 0; r < 6; r++) begin
      int unsigned dw = $urandom_range(0, 6);
      int unsigned n  = $urandom_range(1, 4);
      set_div(dw);
      rd(2'd2, v); check("div_readback", v, (dw < 2) ? 32'd2 : dw);
      for (int i = 0; i < int'(n); i++) push_byte(8'($urandom), 1'b1);
      wait_idle(1000);
    end

    // Overflow with EN=0, then drain in push order.
    wr(2'd1, 32'h0);
    set_div($urandom_range(2, 4));
    for (int i = 0; i < 9; i++) push_byte(8'($urandom), i < 8);
    rd(2'd3, v); check("ovf_count", v, 32'd8);
    rd(2'd1, v); check("ovf_ctrl", v, 32'h24);
    wr(2'd1, 32'h4);
    rd(2'd1, v); check("ovf_cleared", v, 32'h20);
    wr(2'd1, 32'h1);
    wait_idle(2000);

    // IRQ behaviour.
    set_div(2);
    wr(2'd1, 32'h3);
    check("irq_idle_empty", {31'd0, bus.IRQ}, 32'd1);
    push_byte(8'h01, 1'b1);
    check("irq_after_push", {31'd0, bus.IRQ}, 32'd0);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.IRQ) hi++;
    end
    check("irq_low_busy", hi, 32'd0);
    @(posedge clk); #1;
    check("irq_drained", {31'd0, bus.IRQ}, 32'd1);
    push_byte(8'h02, 1'b1);
    check("irq_second_push", {31'd0, bus.IRQ}, 32'd0);
    wait_idle(200);
    wr(2'd1, 32'h1);
    check("irq_ie_off", {31'd0, bus.IRQ}, 32'd0);

    // Mid-frame DIV write affects only later frames.
    set_div(3);
    push_byte(8'h3C, 1'b1);
    repeat (4) @(posedge clk);
    wr(2'd2, 32'd1);
    rd(2'd2, v); check("mid_div_clamp", v, 32'd2);
    wait_idle(300);
    cur_div = 2;

    // Reset in the middle of the data bits.
    push_byte(8'hC3, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    abort_mon = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    cur_div = 16;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    rd(2'd3, v); check("mid_rst_count", v, 32'd0);
    rd(2'd2, v); check("mid_rst_div", v, 32'd16);
    rd(2'd1, v); check("mid_rst_ctrl", v, 32'h10);
    repeat (2) @(posedge clk);
    #1;
    abort_mon = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_line_idle", {31'd0, tx}, 32'd1);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bridge_uart_tx.md
Name: bridge_uart_tx

Overview:
Memory-mapped UART transmitter on the Bridge peripheral bus, alongside Timer0/Timer1, using the same slave interface as TC (Addr[31:2], WE, Din, Dout, IRQ).
- CPU stores bytes into an internal FIFO; a baud-divider FSM serialises them 8N1 on tx.
- IRQ is a level request the Bridge maps onto a free HWInt bit, signalling "transmitter drained".

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
DIV_RESET, 16, reset value of DIV (clk cycles per bit); at least 2.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
Addr  input  30 (Addr[31:2])  word address from Bridge; only Addr[3:2] decoded.
WE  input  1  write strobe; Bridge asserts it only for addresses in this device's window.
Din  input  32  write data.
Dout  output  32  read data; combinational function of Addr[3:2] and current state.
IRQ  output  1  registered level interrupt request.
tx  output  1  serial line; idles high.

Behaviour:
Register map (Addr[3:2]):
- 0 TXDATA: write pushes Din[7:0]; reads return 0.
- 1 CTRL: bit0 EN, bit1 IE, bit2 OVF (sticky), bit3 reserved, bit4 EMPTY, bit5 FULL, bit6 BUSY (FSM not IDLE), other bits 0.
  - A write loads EN/IE from Din[1:0].
  - Din[2]=1 clears OVF.
  - Status bits are read-only.
- 2 DIV: bits[15:0]. A written value below 2 is stored as 2. Upper bits read 0.
- 3 COUNT: FIFO occupancy, zero-extended.

Reset values: tx=1, IRQ=0, EN=0, IE=0, OVF=0, DIV=DIV_RESET, FIFO empty, FSM IDLE, bit counter 0, baud counter 0.

FIFO:
- A push while full is dropped and sets OVF.
- Push and pop in the same cycle are both performed. Count is unchanged, and a push when full succeeds if a pop happens in that cycle.
- Pointers wrap modulo FIFO_DEPTH.

FSM, with states IDLE, START, DATA, STOP:
- IDLE -> START when EN=1 and FIFO non-empty.
  - The head is popped into the shift register on this transition.
  - DIV is latched into the active divisor.
  - tx=0 from the next cycle.
- Each bit lasts exactly active-divisor cycles. The baud counter counts 0..div-1, and the bit ends at div-1.
- START -> DATA: 8 data bits, LSB first, shift right each bit.
- DATA -> STOP after bit 7: tx=1 for one bit time.
- End of STOP:
  - If EN=1 and FIFO non-empty, go straight to START (pop and latch DIV). There is no idle gap, so the frame period is exactly 10*div.
  - Otherwise go to IDLE.
- EN cleared mid-frame: the current frame completes, then the FSM stays IDLE with FIFO contents retained.
- A DIV write mid-frame affects only the next frame.
- tx is driven from a register, so it is glitch-free.

IRQ:
- Registered each cycle as IE & EMPTY & (state==IDLE), evaluated on the next state.
- Deasserts the cycle after a push or after IE is cleared.

Reset asserted mid-frame returns to reset values on that clock edge. tx goes high, and the FIFO contents are discarded.

Optional Feature:
UART_PARITY_EN
- Defined:
  - CTRL bit3 = PE (read/write).
  - When PE=1, a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for one bit time, giving an 11*div frame.
  - PE is sampled at frame start.
- Undefined: bit3 reads 0 and writes to it are ignored; frames are always 10*div.

Test Plan:
- Reset, then read CTRL -> EMPTY=1, others 0. Read DIV -> 16. tx=1, IRQ=0.
- Write DIV=4, CTRL=1, TXDATA=0x55 -> tx goes low 1 cycle later and stays low 4 cycles. Then sees 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. BUSY=0 after 40 cycles.
- Write DIV=2, push 0xA5 then 0x0F with EN=1 -> the second start bit begins exactly 20 cycles after the first. tx shows no idle gap.
- EN=0, push 9 bytes into an 8-deep FIFO -> COUNT=8, FULL=1, OVF=1. Write CTRL Din=0x4 -> OVF=0. Then EN=1 sends 8 frames in push order.
- IE=1, EN=1, push 0x01 -> IRQ=0 while busy, then IRQ=1 one cycle after returning to IDLE. A push of 0x02 -> IRQ=0 on the next cycle.
- Mid-frame: write DIV=1 -> reads back 2, current frame timing unchanged. Assert reset in DATA state -> tx=1, COUNT=0, DIV=16 after the edge.
